// File: rtl/bcd3_bin8_pkg.sv
// Shared definitions for the three-digit BCD to binary converter.
package bcd3_bin8_pkg;

  // IDLE  | waiting for START
  // CHECK | validating latched digits
  // SHIFT | reverse double-dabble iterations
  // FIN   | registering result, DONE follows
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int BCD_DIGITS = 3;
  localparam int BIN_W      = 10;
  localparam int OUT_W      = 8;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SR_W       = BCD_W + BIN_W;

  localparam logic [3:0] BCD_ADJ   = 4'd3;
  localparam logic [3:0] ITER_LAST = 4'd9;

  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step for reverse double-dabble: after a right
// shift a digit that picked up the upper digit's LSB gained 8 instead of 5.
module bcd_digit_adj
  import bcd3_bin8_pkg::*;
(
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= 4'd8) ? (i_d - BCD_ADJ) : i_d;

endmodule

// File: rtl/bcd3_bin8.sv
// Sequential 3-digit BCD to 8-bit binary converter, one shift per clock.
module bcd3_bin8
  import bcd3_bin8_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [3:0]       HUND,
  input  logic [3:0]       TEN,
  input  logic [3:0]       ONE,
  output logic [OUT_W-1:0] NUM_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic             OVF
);

  state_t           r_state;
  state_t           w_next;
  logic [SR_W-1:0]  r_sr;
  logic [SR_W-1:0]  w_shifted;
  logic [SR_W-1:0]  w_sr_step;
  logic [BCD_W-1:0] w_adj;
  logic [3:0]       r_cnt;
  logic             r_bad;
  logic             w_any_bad;
  logic             w_accept;
  logic             w_ovf;
  logic [OUT_W-1:0] r_num;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_ovf;

  // START during the DONE cycle is dropped; IDLE accepts only once DONE is low.
  assign w_accept  = START && !r_done;
  assign w_shifted = {1'b0, r_sr[SR_W-1:1]};

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_d (w_shifted[BIN_W + 4*g +: 4]),
      .o_d (w_adj[4*g +: 4])
    );
  end

  assign w_sr_step = {w_adj, w_shifted[BIN_W-1:0]};

  assign w_any_bad = digit_bad(r_sr[SR_W-1 -: 4]) ||
                     digit_bad(r_sr[SR_W-5 -: 4]) ||
                     digit_bad(r_sr[BIN_W +: 4]);

  assign w_ovf = |r_sr[BIN_W-1:OUT_W];

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CHECK;
      CHECK:   w_next = w_any_bad ? FIN : SHIFT;
      SHIFT:   if (r_cnt == ITER_LAST) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Shift register, iteration counter and latched digit-error flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_bad <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) r_sr <= {HUND, TEN, ONE, {BIN_W{1'b0}}};
        end
        CHECK: begin
          r_bad <= w_any_bad;
          r_cnt <= '0;
        end
        SHIFT: begin
          r_sr  <= w_sr_step;
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Output registers; result and flags hold until the next FIN.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_num  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= (r_state == FIN);
      r_busy <= (r_state != IDLE);
      if (r_state == FIN) begin
        if (r_bad) begin
          r_num <= '0;
          r_err <= 1'b1;
          r_ovf <= 1'b0;
        end else begin
          r_num <= w_ovf ? {OUT_W{1'b1}} : r_sr[OUT_W-1:0];
          r_err <= 1'b0;
          r_ovf <= w_ovf;
        end
      end
    end
  end

  assign NUM_OUT = r_num;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ERR     = r_err;
  assign OVF     = r_ovf;

endmodule

// File: tb/tb_bcd3_bin8.sv
// Bench for bcd3_bin8: behavioural model plus per-cycle compare.
module tb_bcd3_bin8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] hund, ten, one;
  logic [7:0] num_out;
  logic       busy, done, err, ovf;

  bcd3_bin8 dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .START   (start),
    .HUND    (hund),
    .TEN     (ten),
    .ONE     (one),
    .NUM_OUT (num_out),
    .BUSY    (busy),
    .DONE    (done),
    .ERR     (err),
    .OVF     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Literal expectations attached to directed conversions (written by stimulus).
  bit         lit_valid;
  logic [7:0] lit_num;
  bit         lit_err, lit_ovf;
  int         lit_lat, lit_busy;

  // Snapshot of outputs taken just after reset is asserted mid-cycle.
  logic [11:0] snap;
  int          snap_seq;

  // Compare-process state.
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int seen_seq = 0;

  bit         m_active;
  int         m_acc, m_done_at;
  logic [7:0] p_num, h_num;
  bit         p_err, p_ovf, h_err, h_ovf;
  bit         p_lit, p_lerr, p_lovf;
  logic [7:0] p_lnum;
  int         p_llat, p_lbusy;
  int         busy_cnt;
  bit         exp_done, exp_busy;
  int         v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // Model update on each active edge, then compare 1 time unit later.
  always begin
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      m_active = 0;
      h_num = 8'h00; h_err = 0; h_ovf = 0;
    end else begin
      if (m_active && edge_n > m_done_at + 1) m_active = 0;
      if (!m_active && start) begin
        m_active = 1;
        m_acc    = edge_n;
        busy_cnt = 0;
        if (hund > 4'd9 || ten > 4'd9 || one > 4'd9) begin
          p_num = 8'h00; p_err = 1; p_ovf = 0;
          m_done_at = edge_n + 2;
        end else begin
          v = int'(hund) * 100 + int'(ten) * 10 + int'(one);
          p_ovf = (v > 255);
          p_num = p_ovf ? 8'hFF : v[7:0];
          p_err = 0;
          m_done_at = edge_n + 12;
        end
        p_lit = lit_valid; p_lnum = lit_num; p_lerr = lit_err; p_lovf = lit_ovf;
        p_llat = lit_lat;  p_lbusy = lit_busy;
      end
    end
    #1;
    if (snap_seq != seen_seq) begin
      seen_seq = snap_seq;
      check("async_reset_outputs", 32'(snap), 32'h0);
    end
    exp_done = m_active && (edge_n == m_done_at);
    exp_busy = m_active && (edge_n > m_acc) && (edge_n <= m_done_at);
    if (exp_done) begin
      h_num = p_num; h_err = p_err; h_ovf = p_ovf;
    end
    if (busy) busy_cnt++;
    check("done", 32'(done), 32'(exp_done));
    check("busy", 32'(busy), 32'(exp_busy));
    check("num_out", 32'(num_out), 32'(h_num));
    check("err", 32'(err), 32'(h_err));
    check("ovf", 32'(ovf), 32'(h_ovf));
    if (done && exp_done && p_lit) begin
      check("lit_num", 32'(num_out), 32'(p_lnum));
      check("lit_err", 32'(err), 32'(p_lerr));
      check("lit_ovf", 32'(ovf), 32'(p_lovf));
      check("lit_latency", 32'(edge_n - m_acc), 32'(p_llat));
      check("lit_busy_cycles", 32'(busy_cnt), 32'(p_lbusy));
    end
    if (done && !err) check("bcd_field_zero", 32'(dut.r_sr[21:10]), 32'h0);
  end

  task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input logic [7:0] ln, input bit le, input bit lo,
                          input int lat, input int bcyc);
    @(negedge clk);
    hund = h; ten = t; one = o;
    lit_num = ln; lit_err = le; lit_ovf = lo; lit_lat = lat; lit_busy = bcyc;
    lit_valid = 1; start = 1;
    @(negedge clk);
    start = 0; lit_valid = 0;
    hund = 4'($urandom_range(0, 15));
    ten  = 4'($urandom_range(0, 15));
    one  = 4'($urandom_range(0, 15));
    repeat (16) @(negedge clk);
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    rst_n = 0; start = 0; hund = 0; ten = 0; one = 0;
    lit_valid = 0; lit_num = 0; lit_err = 0; lit_ovf = 0; lit_lat = 0; lit_busy = 0;
    snap = 0; snap_seq = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    run_conv(4'd2, 4'd0, 4'd0, 8'hC8, 0, 0, 12, 12);
    run_conv(4'd2, 4'd5, 4'd5, 8'hFF, 0, 0, 12, 12);
    run_conv(4'd0, 4'd0, 4'd0, 8'h00, 0, 0, 12, 12);
    run_conv(4'd0, 4'd0, 4'd9, 8'h09, 0, 0, 12, 12);
    run_conv(4'd2, 4'd5, 4'd6, 8'hFF, 0, 1, 12, 12);
    run_conv(4'd9, 4'd9, 4'd9, 8'hFF, 0, 1, 12, 12);
    run_conv(4'd1, 4'hA, 4'd3, 8'h00, 1, 0, 2, 2);
    run_conv(4'd1, 4'd2, 4'd3, 8'h7B, 0, 0, 12, 12);

    // START held for 40 cycles: accepted only from IDLE after each DONE.
    @(negedge clk);
    hund = 4'd0; ten = 4'd4; one = 4'd2;
    lit_num = 8'h2A; lit_err = 0; lit_ovf = 0; lit_lat = 12; lit_busy = 12;
    lit_valid = 1; start = 1;
    repeat (40) @(negedge clk);
    start = 0; lit_valid = 0;
    repeat (20) @(negedge clk);

    // Reset in the middle of a 999 conversion.
    hund = 4'd9; ten = 4'd9; one = 4'd9; start = 1;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    rst_n = 0;
    #1;
    snap = {num_out, busy, done, err, ovf};
    snap_seq++;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    run_conv(4'd1, 4'd0, 4'd0, 8'h64, 0, 0, 12, 12);

    // Random traffic: START pulses, digit changes while busy, invalid digits.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      hund  = rnd_digit();
      ten   = rnd_digit();
      one   = rnd_digit();
    end
    start = 0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
